// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline control core for a 5-stage MIPS datapath.
//
// Holds the instruction of each of the D, E, M and W stages. It detects
// hazards with the Tuse/Tnew method, selects operand forwarding paths, and
// sequences a multi-cycle multiply/divide unit.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   f_instr                 instruction fetched this cycle
//   d/e/m/w_instr           instruction held in each stage (0 = NOP)
//   stall                   hazard stall: D holds and a bubble goes into E
//   pc_enable, d_enable     ~stall
//   fm_d1/fm_d2/fm_e1/fm_e2 operand source: 0 = RF/pipe reg, 1 = M ALU, 2 = W data
//   fm_m2                   M store-data source: 0 = pipe reg, 1 = W data
//   md_start, md_op         start pulse and op (0 = mult, 1 = div) for the mult/div unit
//   md_busy                 mult/div unit is still working
//   w_rf_we, w_rf_waddr     register-file write port for the W instruction
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] f_instr,
  output logic [31:0] d_instr,
  output logic [31:0] e_instr,
  output logic [31:0] m_instr,
  output logic [31:0] w_instr,
  output logic        stall,
  output logic        pc_enable,
  output logic        d_enable,
  output logic [1:0]  fm_d1,
  output logic [1:0]  fm_d2,
  output logic [1:0]  fm_e1,
  output logic [1:0]  fm_e2,
  output logic        fm_m2,
  output logic        md_start,
  output logic        md_op,
  output logic        md_busy,
  output logic        w_rf_we,
  output logic [4:0]  w_rf_waddr
);

  typedef enum logic [3:0] {
    I_NOP, I_ALUR, I_MULT, I_DIV, I_MFX, I_ORI, I_LUI, I_LW, I_SW, I_BEQ
  } icls_t;

  logic [CNT_W-1:0] md_cnt;

  function automatic icls_t class_of(input logic [5:0] op, input logic [5:0] fn);
    icls_t c;
    c = I_NOP;
    case (op)
      6'h00: begin
        case (fn)
          6'h21, 6'h23: c = I_ALUR;
          6'h18:        c = I_MULT;
          6'h1A:        c = I_DIV;
          6'h10, 6'h12: c = I_MFX;
          default:      c = I_NOP;
        endcase
      end
      6'h0D:   c = I_ORI;
      6'h0F:   c = I_LUI;
      6'h23:   c = I_LW;
      6'h2B:   c = I_SW;
      6'h04:   c = I_BEQ;
      default: c = I_NOP;
    endcase
    return c;
  endfunction

  // Source fields read as 0 when the instruction does not read them, so an
  // unused field can never trigger a stall or a forward.
  function automatic logic [4:0] rs_src(input icls_t c, input logic [4:0] rs);
    return (c inside {I_ALUR, I_MULT, I_DIV, I_ORI, I_LW, I_SW, I_BEQ}) ? rs : 5'd0;
  endfunction

  function automatic logic [4:0] rt_src(input icls_t c, input logic [4:0] rt);
    return (c inside {I_ALUR, I_MULT, I_DIV, I_SW, I_BEQ}) ? rt : 5'd0;
  endfunction

  function automatic logic [4:0] dst_of(input icls_t c, input logic [4:0] rt,
                                        input logic [4:0] rd);
    logic [4:0] r;
    r = 5'd0;
    if (c inside {I_ALUR, I_MFX})             r = rd;
    else if (c inside {I_ORI, I_LUI, I_LW})   r = rt;
    return r;
  endfunction

  function automatic logic [1:0] tnew_d_of(input icls_t c);
    logic [1:0] t;
    t = 2'd0;
    if (c == I_LW)                                   t = 2'd3;
    else if (c inside {I_ALUR, I_MFX, I_ORI, I_LUI}) t = 2'd2;
    return t;
  endfunction

  function automatic logic [1:0] tuse_rs_of(input icls_t c);
    return (c == I_BEQ) ? 2'd0 : 2'd1;
  endfunction

  function automatic logic [1:0] tuse_rt_of(input icls_t c);
    logic [1:0] t;
    t = 2'd1;
    if (c == I_SW)       t = 2'd2;
    else if (c == I_BEQ) t = 2'd0;
    return t;
  endfunction

  function automatic logic [1:0] sat_sub(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? (a - b) : 2'd0;
  endfunction

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                  input logic [4:0] m_dst, input logic [1:0] m_tnew);
    return (src != 5'd0) &&
           (((src == e_dst) && (e_tnew > tuse)) || ((src == m_dst) && (m_tnew > tuse)));
  endfunction

  // W always has Tnew = 0 (largest Tnew at D is 3), so W needs no Tnew term.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_dst,
                                         input logic [1:0] m_tnew, input logic [4:0] w_dst);
    logic [1:0] s;
    s = 2'd0;
    if ((src != 5'd0) && (src == m_dst) && (m_tnew == 2'd0)) s = 2'd1;
    else if ((src != 5'd0) && (src == w_dst))                s = 2'd2;
    return s;
  endfunction

  icls_t      cls_d, cls_e, cls_m, cls_w;
  logic [4:0] d_rs, d_rt, e_rs, e_rt, e_dst, m_rt, m_dst, w_dst;
  logic [1:0] e_tnew, m_tnew;
  logic       stall_data, stall_md;

  always_comb begin
    cls_d = class_of(d_instr[31:26], d_instr[5:0]);
    cls_e = class_of(e_instr[31:26], e_instr[5:0]);
    cls_m = class_of(m_instr[31:26], m_instr[5:0]);
    cls_w = class_of(w_instr[31:26], w_instr[5:0]);

    d_rs  = rs_src(cls_d, d_instr[25:21]);
    d_rt  = rt_src(cls_d, d_instr[20:16]);
    e_rs  = rs_src(cls_e, e_instr[25:21]);
    e_rt  = rt_src(cls_e, e_instr[20:16]);
    m_rt  = rt_src(cls_m, m_instr[20:16]);
    e_dst = dst_of(cls_e, e_instr[20:16], e_instr[15:11]);
    m_dst = dst_of(cls_m, m_instr[20:16], m_instr[15:11]);
    w_dst = dst_of(cls_w, w_instr[20:16], w_instr[15:11]);

    e_tnew = sat_sub(tnew_d_of(cls_e), 2'd1);
    m_tnew = sat_sub(tnew_d_of(cls_m), 2'd2);

    stall_data = hazard(d_rs, tuse_rs_of(cls_d), e_dst, e_tnew, m_dst, m_tnew) ||
                 hazard(d_rt, tuse_rt_of(cls_d), e_dst, e_tnew, m_dst, m_tnew);
    // HI/LO users wait while the unit runs or while a new op is entering it.
    stall_md   = (cls_d inside {I_MULT, I_DIV, I_MFX}) &&
                 (md_busy || (cls_e inside {I_MULT, I_DIV}));
  end

  assign stall      = stall_data | stall_md;
  assign pc_enable  = ~stall;
  assign d_enable   = ~stall;
  assign fm_d1      = fwd_sel(d_rs, m_dst, m_tnew, w_dst);
  assign fm_d2      = fwd_sel(d_rt, m_dst, m_tnew, w_dst);
  assign fm_e1      = fwd_sel(e_rs, m_dst, m_tnew, w_dst);
  assign fm_e2      = fwd_sel(e_rt, m_dst, m_tnew, w_dst);
  assign fm_m2      = (cls_m == I_SW) && (m_rt != 5'd0) && (m_rt == w_dst);
  assign md_start   = (cls_e inside {I_MULT, I_DIV});
  assign md_op      = (cls_e == I_DIV);
  assign md_busy    = (md_cnt != '0);
  assign w_rf_we    = (w_dst != 5'd0);
  assign w_rf_waddr = w_dst;

  // Stage boundaries F->D->E->M->W and the mult/div busy counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_instr <= '0;
      e_instr <= '0;
      m_instr <= '0;
      w_instr <= '0;
      md_cnt  <= '0;
    end else begin
      if (!stall) d_instr <= f_instr;
      e_instr <= stall ? 32'd0 : d_instr;
      m_instr <= e_instr;
      w_instr <= m_instr;
      if (md_start)
        md_cnt <= md_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] f_instr;
  logic [31:0] d_instr, e_instr, m_instr, w_instr;
  logic        stall, pc_enable, d_enable;
  logic [1:0]  fm_d1, fm_d2, fm_e1, fm_e2;
  logic        fm_m2, md_start, md_op, md_busy, w_rf_we;
  logic [4:0]  w_rf_waddr;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .f_instr(f_instr),
    .d_instr(d_instr), .e_instr(e_instr), .m_instr(m_instr), .w_instr(w_instr),
    .stall(stall), .pc_enable(pc_enable), .d_enable(d_enable),
    .fm_d1(fm_d1), .fm_d2(fm_d2), .fm_e1(fm_e1), .fm_e2(fm_e2), .fm_m2(fm_m2),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .w_rf_we(w_rf_we), .w_rf_waddr(w_rf_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Present an instruction, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [31:0] ins);
    f_instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stages"}, {d_instr | e_instr | m_instr | w_instr}, 32'd0);
    chk({tag, "_stall"},  {31'd0, stall}, 32'd0);
    chk({tag, "_fm"},     {23'd0, fm_d1, fm_d2, fm_e1, fm_e2, fm_m2}, 32'd0);
    chk({tag, "_busy"},   {31'd0, md_busy}, 32'd0);
  endtask

  logic [31:0] LW1, ADDU2, ORI3, BEQ3, ADDU4, SW4, MULT12, MFLO3, DIV12;

  initial begin
    LW1    = i_op(6'h23, 5'd0, 5'd1, 16'd0);
    ADDU2  = r_op(5'd1, 5'd1, 5'd2, 6'h21);
    ORI3   = i_op(6'h0D, 5'd0, 5'd3, 16'd5);
    BEQ3   = i_op(6'h04, 5'd3, 5'd3, 16'd4);
    ADDU4  = r_op(5'd5, 5'd6, 5'd4, 6'h21);
    SW4    = i_op(6'h2B, 5'd0, 5'd4, 16'd0);
    MULT12 = r_op(5'd1, 5'd2, 5'd0, 6'h18);
    MFLO3  = r_op(5'd0, 5'd0, 5'd3, 6'h12);
    DIV12  = r_op(5'd1, 5'd2, 5'd0, 6'h1A);

    reset_n = 1'b1;
    f_instr = 32'd0;
    #1 reset_n = 1'b0;
    #2;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) step(32'd0);
    chk_idle("nops");
    chk("nops_pc_en", {31'd0, pc_enable}, 32'd1);

    // lw $1 then addu $2,$1,$1: one load-use stall, then W forwarding in E
    step(LW1);
    step(ADDU2);
    chk("lw_stall", {31'd0, stall}, 32'd1);
    chk("lw_enables", {30'd0, pc_enable, d_enable}, 32'd0);
    step(32'd0);
    chk("lw_d_held", d_instr, ADDU2);
    chk("lw_bubble", e_instr, 32'd0);
    chk("lw_m", m_instr, LW1);
    chk("lw_nostall", {31'd0, stall}, 32'd0);
    step(32'd0);
    chk("lw_e_addu", e_instr, ADDU2);
    chk("lw_fm_e", {30'd0, fm_e1, fm_e2}, {28'd0, 2'd2, 2'd2});
    chk("lw_w_we", {26'd0, w_rf_we, w_rf_waddr}, {26'd0, 1'b1, 5'd1});
    repeat (3) step(32'd0);

    // ori $3 then beq $3,$3: stall on E Tnew 1 > Tuse 0, then M forwarding in D
    step(ORI3);
    step(BEQ3);
    chk("beq_stall", {31'd0, stall}, 32'd1);
    step(32'd0);
    chk("beq_d_held", d_instr, BEQ3);
    chk("beq_nostall", {31'd0, stall}, 32'd0);
    chk("beq_fm_d", {30'd0, fm_d1, fm_d2}, {28'd0, 2'd1, 2'd1});
    repeat (4) step(32'd0);

    // addu $4 then sw $4: no stall, M forwarding in E, then W store-data forward
    step(ADDU4);
    step(SW4);
    chk("sw_nostall", {31'd0, stall}, 32'd0);
    step(32'd0);
    chk("sw_fm_e", {30'd0, fm_e1, fm_e2}, {28'd0, 2'd0, 2'd1});
    chk("sw_fm_m2_early", {31'd0, fm_m2}, 32'd0);
    step(32'd0);
    chk("sw_m", m_instr, SW4);
    chk("sw_fm_m2", {31'd0, fm_m2}, 32'd1);
    chk("sw_w_we", {26'd0, w_rf_we, w_rf_waddr}, {26'd0, 1'b1, 5'd4});
    repeat (3) step(32'd0);

    // mult $1,$2 then mflo $3: start pulse, 5 busy cycles, mflo held until done
    step(MULT12);
    chk("mult_nostart_in_d", {31'd0, md_start}, 32'd0);
    step(MFLO3);
    chk("mult_start", {30'd0, md_start, md_op}, {30'd0, 2'b10});
    chk("mult_stall_e", {31'd0, stall}, 32'd1);
    chk("mult_busy0", {31'd0, md_busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(32'd0);
      chk($sformatf("mult_busy_c%0d", i), {29'd0, md_busy, stall, md_start}, {29'd0, 3'b110});
      chk($sformatf("mult_d_held_c%0d", i), d_instr, MFLO3);
    end
    step(32'd0);
    chk("mult_done", {30'd0, md_busy, stall}, 32'd0);
    chk("mult_mflo_d", d_instr, MFLO3);
    step(32'd0);
    chk("mult_mflo_e", e_instr, MFLO3);
    chk("mult_d_nop", d_instr, 32'd0);
    repeat (3) step(32'd0);

    // div in E, then asynchronous reset mid-operation
    step(DIV12);
    step(32'd0);
    chk("div_start", {30'd0, md_start, md_op}, {30'd0, 2'b11});
    step(32'd0);
    chk("div_busy", {31'd0, md_busy}, 32'd1);
    chk("div_m", m_instr, DIV12);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("div_rst");
    chk("div_rst_start", {31'd0, md_start}, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(32'd0);
    chk_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
